// File: rtl/irq_timer_ctrl.sv
// ---------------------------------------------------------------------------
// irq_timer_ctrl
//
// Machine-level interrupt source for the core's CSR register file. It holds a
// memory-mapped 64-bit machine timer (mtime / mtimecmp), synchronises an
// asynchronous external interrupt line, arbitrates between the two sources
// and presents a registered 2-bit interrupt code to the CSR file. The
// request / acknowledge / return handshake closes through epc_taken and
// is_mret.
//
// Register window (32 bytes at BASE_ADDR, word offset = bus_addr[4:2]):
//   0 mtime_lo     RW     1 mtime_hi      RW
//   2 mtimecmp_lo  RW     3 mtimecmp_hi   RW
//   4 ctrl         RW     bit0 ten (timer enable), bit1 een (external enable)
//   5 status              bit0 mtip (RO), bit1 meip (write-1-to-clear)
//   6,7                   read 0, writes ignored
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   bus_addr   in   [31:0] MEM-stage byte address
//   bus_wdata  in   [31:0] store data
//   bus_we     in   store strobe (word writes only)
//   bus_re     in   load strobe
//   bus_rdata  out  [31:0] load data, combinational, 0 unless selected+read
//   ext_irq    in   asynchronous external interrupt line, active-high
//   epc_taken  in   CSR file redirected to the trap vector / mret target
//   is_mret    in   mret is executing
//   interrupt  out  [1:0] 00 none, 01 timer, 10 external (11 never driven)
// ---------------------------------------------------------------------------
module irq_timer_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_we,
  input  logic        bus_re,
  output logic [31:0] bus_rdata,
  input  logic        ext_irq,
  input  logic        epc_taken,
  input  logic        is_mret,
  output logic [1:0]  interrupt
);

  localparam int unsigned   PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  localparam logic [1:0] IRQ_NONE = 2'b00;
  localparam logic [1:0] IRQ_TMR  = 2'b01;
  localparam logic [1:0] IRQ_EXT  = 2'b10;

  localparam logic [2:0] OFF_MTIME_LO = 3'd0;
  localparam logic [2:0] OFF_MTIME_HI = 3'd1;
  localparam logic [2:0] OFF_CMP_LO   = 3'd2;
  localparam logic [2:0] OFF_CMP_HI   = 3'd3;
  localparam logic [2:0] OFF_CTRL     = 3'd4;
  localparam logic [2:0] OFF_STATUS   = 3'd5;

  // State
  logic [63:0]   mtime_q,    mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic [PW-1:0] presc_q,    presc_d;
  logic [1:0]    ctrl_q,     ctrl_d;
  logic          meip_q,     meip_d;
  logic          sync1_q,    sync2_q,  sync3_q;
  logic [1:0]    state_q,    state_d;
  logic [1:0]    irq_q,      irq_d;

  // Decode
  logic       sel;
  logic [2:0] offset;
  logic       wr;
  logic       presc_tick;
  logic       mtip;
  logic       ext_rise;
  logic       ext_ok;
  logic       tmr_ok;
  logic       ack_ext;
  logic       unused_addr;

  assign sel         = (bus_addr[31:5] == BASE_ADDR[31:5]);
  assign offset      = bus_addr[4:2];
  assign wr          = sel & bus_we;
  assign unused_addr = ^bus_addr[1:0];

  assign presc_tick  = (presc_q == PRESC_MAX);
  assign mtip        = (mtime_q >= mtimecmp_q);
  // sync3_q holds the previous synchronised level, so a rise is seen once.
  assign ext_rise    = sync2_q & ~sync3_q;
  assign ext_ok      = meip_q & ctrl_q[1];
  assign tmr_ok      = mtip & ctrl_q[0];
  assign ack_ext     = (state_q == ST_REQ) & epc_taken & (irq_q == IRQ_EXT);

  // Register-file next state
  always_comb begin : reg_next
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    ctrl_d     = ctrl_q;
    meip_d     = meip_q;
    presc_d    = presc_tick ? '0 : presc_q + PW'(1);

    // A store to either mtime half overrides this cycle's increment and
    // restarts the prescaler so the new value gets a full period.
    if (wr && (offset == OFF_MTIME_LO || offset == OFF_MTIME_HI)) begin
      presc_d = '0;
      if (offset == OFF_MTIME_HI) mtime_d[63:32] = bus_wdata;
      else                        mtime_d[31:0]  = bus_wdata;
    end else if (presc_tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (wr) begin
      case (offset)
        OFF_CMP_LO: mtimecmp_d[31:0]  = bus_wdata;
        OFF_CMP_HI: mtimecmp_d[63:32] = bus_wdata;
        OFF_CTRL:   ctrl_d            = bus_wdata[1:0];
        default:    ;
      endcase
    end

    // Clears first, set last: a coincident edge keeps meip pending.
    if (wr && offset == OFF_STATUS && bus_wdata[1]) meip_d = 1'b0;
    if (ack_ext)                                    meip_d = 1'b0;
    if (ext_rise)                                   meip_d = 1'b1;
  end

  // Request / acknowledge / return FSM. irq_q is the latched code and is
  // only updated on state transitions, so it stays stable throughout REQ.
  always_comb begin : fsm_next
    state_d = state_q;
    irq_d   = irq_q;
    case (state_q)
      ST_IDLE: begin
        if (ext_ok) begin
          state_d = ST_REQ;
          irq_d   = IRQ_EXT;
        end else if (tmr_ok) begin
          state_d = ST_REQ;
          irq_d   = IRQ_TMR;
        end
      end
      ST_REQ: begin
        if (epc_taken) begin
          state_d = ST_SERVICE;
          irq_d   = IRQ_NONE;
        end
      end
      ST_SERVICE: begin
        if (is_mret) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        irq_d   = IRQ_NONE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      presc_q    <= '0;
      ctrl_q     <= '0;
      meip_q     <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      state_q    <= ST_IDLE;
      irq_q      <= IRQ_NONE;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      presc_q    <= presc_d;
      ctrl_q     <= ctrl_d;
      meip_q     <= meip_d;
      sync1_q    <= ext_irq;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      state_q    <= state_d;
      irq_q      <= irq_d;
    end
  end

  // Load data reflects pre-edge register state.
  always_comb begin : read_mux
    bus_rdata = '0;
    if (sel && bus_re) begin
      case (offset)
        OFF_MTIME_LO: bus_rdata = mtime_q[31:0];
        OFF_MTIME_HI: bus_rdata = mtime_q[63:32];
        OFF_CMP_LO:   bus_rdata = mtimecmp_q[31:0];
        OFF_CMP_HI:   bus_rdata = mtimecmp_q[63:32];
        OFF_CTRL:     bus_rdata = {30'd0, ctrl_q};
        OFF_STATUS:   bus_rdata = {30'd0, meip_q, mtip};
        default:      bus_rdata = '0;
      endcase
    end
  end

  assign interrupt = irq_q;

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_irq_timer_ctrl
//
// Directed bench for irq_timer_ctrl (BASE_ADDR 0x2000, PRESCALE 1). Inputs
// change on the falling edge; outputs are sampled 1 ns after a rising edge
// or after a falling edge, never on the active edge.
// ---------------------------------------------------------------------------
module tb_irq_timer_ctrl;

  localparam logic [31:0] A_MTIME_LO = 32'h0000_2000;
  localparam logic [31:0] A_MTIME_HI = 32'h0000_2004;
  localparam logic [31:0] A_CMP_LO   = 32'h0000_2008;
  localparam logic [31:0] A_CMP_HI   = 32'h0000_200C;
  localparam logic [31:0] A_CTRL     = 32'h0000_2010;
  localparam logic [31:0] A_STATUS   = 32'h0000_2014;
  localparam logic [31:0] A_OFF6     = 32'h0000_2018;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_rdata;
  logic        ext_irq;
  logic        epc_taken;
  logic        is_mret;
  logic [1:0]  interrupt;

  int n_vec  = 0;
  int n_fail = 0;

  irq_timer_ctrl #(
    .BASE_ADDR (32'h0000_2000),
    .PRESCALE  (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_rdata (bus_rdata),
    .ext_irq   (ext_irq),
    .epc_taken (epc_taken),
    .is_mret   (is_mret),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp,
                       input string tag);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_irq(input logic [1:0] exp, input string tag);
    check({30'd0, interrupt}, {30'd0, exp}, tag);
  endtask

  // Combinational read in the current cycle; caller picks the cycle.
  task automatic read_check(input logic [31:0] addr, input logic [31:0] exp,
                            input string tag);
    bus_addr = addr;
    bus_re   = 1'b1;
    #1;
    check(bus_rdata, exp, tag);
    bus_re   = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus_addr  = addr;
    bus_wdata = data;
    bus_we    = 1'b1;
    @(posedge clk);
    #1;
    bus_we    = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_epc();
    @(negedge clk);
    epc_taken = 1'b1;
    @(posedge clk);
    #1;
    epc_taken = 1'b0;
  endtask

  task automatic pulse_mret();
    @(negedge clk);
    is_mret = 1'b1;
    @(posedge clk);
    #1;
    is_mret = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_we    = 1'b0;
    bus_re    = 1'b0;
    ext_irq   = 1'b0;
    epc_taken = 1'b0;
    is_mret   = 1'b0;

    // Reset state
    tick(3);
    check_irq(2'b00, "reset_irq");
    @(negedge clk);
    read_check(A_CMP_LO,   32'hFFFF_FFFF, "reset_cmp_lo");
    read_check(A_CMP_HI,   32'hFFFF_FFFF, "reset_cmp_hi");
    read_check(A_MTIME_LO, 32'h0,         "reset_mtime_lo");
    read_check(A_MTIME_HI, 32'h0,         "reset_mtime_hi");
    @(negedge clk);
    reset = 1'b0;

    // Timer: mtimecmp = 10, mtime restarted at 0, then ten = 1
    bus_write(A_CMP_HI, 32'h0);
    bus_write(A_CMP_LO, 32'd10);
    bus_write(A_MTIME_LO, 32'h0);   // mtime = 0 after this edge
    bus_write(A_CTRL, 32'h1);       // mtime = 1 after this edge
    tick(9);                        // mtime = 10 now
    check_irq(2'b00, "tmr_not_yet");
    @(negedge clk);
    read_check(A_MTIME_LO, 32'd10, "tmr_mtime_10");
    tick(1);
    check_irq(2'b01, "tmr_req");
    tick(3);
    check_irq(2'b01, "tmr_hold");
    pulse_epc();
    check_irq(2'b00, "tmr_ack");
    pulse_mret();
    check_irq(2'b00, "tmr_mret_idle");
    tick(1);
    check_irq(2'b01, "tmr_rereq");
    bus_write(A_CMP_LO, 32'd100);
    check_irq(2'b01, "tmr_code_latched");
    @(negedge clk);
    read_check(A_STATUS, 32'h0, "tmr_mtip_clear");
    pulse_epc();
    pulse_mret();
    tick(3);
    check_irq(2'b00, "tmr_no_rereq");

    // External vs timer arbitration
    bus_write(A_CTRL, 32'h0);
    bus_write(A_CMP_LO, 32'h0);     // mtimecmp = 0 -> mtip
    @(negedge clk);
    ext_irq = 1'b1;
    tick(4);
    @(negedge clk);
    read_check(A_STATUS, 32'h3, "arb_status_both");
    bus_write(A_CTRL, 32'h3);
    check_irq(2'b00, "arb_pre_req");
    tick(1);
    check_irq(2'b10, "arb_ext_first");
    pulse_epc();
    check_irq(2'b00, "arb_ext_ack");
    @(negedge clk);
    read_check(A_STATUS, 32'h1, "arb_meip_cleared");
    pulse_mret();
    tick(1);
    check_irq(2'b01, "arb_tmr_next");
    bus_write(A_CTRL, 32'h0);
    check_irq(2'b01, "arb_tmr_latched");
    pulse_epc();
    pulse_mret();
    tick(2);
    check_irq(2'b00, "arb_quiet");
    @(negedge clk);
    ext_irq = 1'b0;

    // External edge with een = 0, then W1C
    bus_write(A_CMP_HI, 32'hFFFF_FFFF);
    tick(3);
    @(negedge clk);
    ext_irq = 1'b1;
    tick(4);
    @(negedge clk);
    read_check(A_STATUS, 32'h2, "een0_meip_set");
    check_irq(2'b00, "een0_no_irq");
    bus_write(A_STATUS, 32'h2);
    @(negedge clk);
    read_check(A_STATUS, 32'h0, "w1c_meip");

    // Bus read gating and empty offsets
    read_check(A_OFF6, 32'h0, "rd_off6");
    read_check(32'h0000_300C, 32'h0, "rd_unselected");
    bus_addr = A_CMP_HI;
    bus_re   = 1'b0;
    #1;
    check(bus_rdata, 32'h0, "rd_no_strobe");

    // 64-bit wrap, then store-vs-increment
    bus_write(A_MTIME_HI, 32'hFFFF_FFFF);
    bus_write(A_MTIME_LO, 32'hFFFF_FFFF);
    @(negedge clk);
    read_check(A_MTIME_LO, 32'hFFFF_FFFF, "wrap_pre_lo");
    read_check(A_MTIME_HI, 32'hFFFF_FFFF, "wrap_pre_hi");
    @(negedge clk);
    read_check(A_MTIME_LO, 32'h0, "wrap_lo");
    read_check(A_MTIME_HI, 32'h0, "wrap_hi");
    bus_write(A_MTIME_LO, 32'h55);
    @(negedge clk);
    read_check(A_MTIME_LO, 32'h55, "wr_beats_inc");

    // Reset while in REQ with external code
    bus_write(A_CTRL, 32'h2);
    @(negedge clk);
    ext_irq = 1'b0;
    tick(3);
    @(negedge clk);
    ext_irq = 1'b1;
    tick(5);
    check_irq(2'b10, "rst_req_ext");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_irq(2'b00, "rst_irq");
    @(negedge clk);
    read_check(A_STATUS, 32'h0, "rst_meip");
    read_check(A_CTRL,   32'h0, "rst_ctrl");
    @(negedge clk);
    reset = 1'b0;
    tick(2);
    check_irq(2'b00, "rst_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
